// File: rtl/mfp_ahb_trace_buffer_pkg.sv
// Shared definitions for the AHB-Lite trace buffer.
// Holds the capture FSM encoding, the HTRANS encodings of the observed bus,
// the trace entry width and the trigger compare helper.
package mfp_ahb_trace_buffer_pkg;

    // Values are visible on the state output, so the encoding is fixed.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArmed     = 2'd1,
        StTriggered = 2'd2,
        StDone      = 2'd3
    } trace_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Entry layout: {write, addr[31:0], data[31:0]}
    localparam int unsigned ENTRY_W = 65;

    // Masked address compare; a zero mask matches every address.
    function automatic logic trig_match(input logic [31:0] addr,
                                        input logic [31:0] tgt,
                                        input logic [31:0] mask);
        return ((addr ^ tgt) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/mfp_ahb_trace_ram.sv
// Simple dual-port trace memory: one synchronous write port, one synchronous
// read port, no reset on the array or the read register so it maps onto block RAM.
// Ports:
//   i_clk              clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr       read port; o_rdata is valid the cycle after i_re
module mfp_ahb_trace_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 65
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mfp_ahb_trace_buffer.sv
// Passive AHB-Lite observer with a triggered circular trace memory.
// Every completed transfer is captured while ARMED/TRIGGERED; after an address
// match plus POST_TRIG further transfers capture freezes (DONE) and the host
// pops the history oldest-first.
// Ports:
//   SI_ClkIn, SI_Reset        clock, synchronous active-high reset
//   HADDR..HTRANS             observed bus (inputs only)
//   trig_addr, trig_mask      masked address trigger
//   arm                       pulse: clear and start capture
//   rd_en                     pop request (DONE, count != 0)
//   rd_valid, rd_data         popped entry, one cycle after rd_en
//   state, count, wrapped     status
module mfp_ahb_trace_buffer
    import mfp_ahb_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int          POST_TRIG  = 16
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HRDATA,
    input  logic [31:0]           HWDATA,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic [31:0]           trig_addr,
    input  logic [31:0]           trig_mask,
    input  logic                  arm,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [ENTRY_W-1:0]    rd_data,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  wrapped
);

    if (POST_TRIG < 0 || POST_TRIG > int'(2**DEPTH_LOG2) - 1) begin : g_bad_post_trig
        $error("POST_TRIG must lie in 0 .. 2**DEPTH_LOG2-1");
    end

    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT     = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2-1:0] POST_CNT_INIT = DEPTH_LOG2'(POST_TRIG);

    trace_state_e            r_state, w_state_d;
    logic [DEPTH_LOG2-1:0]   r_post, w_post_d;
    logic [DEPTH_LOG2-1:0]   r_wptr, r_rptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_wrapped;
    logic                    r_rd_valid;
    logic                    r_pend;
    logic                    r_pend_write;
    logic [31:0]             r_pend_addr;

    logic                    w_addr_acc;
    logic                    w_wr;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_match;
    logic [ENTRY_W-1:0]      w_entry;
    logic [ENTRY_W-1:0]      w_ram_q;

    assign w_addr_acc = HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    // An entry completing in the arm cycle belongs to the previous run: drop it.
    assign w_wr       = HREADY && r_pend && !arm &&
                        (r_state == StArmed || r_state == StTriggered);
    assign w_pop      = rd_en && !arm && (r_state == StDone) && (r_count != '0);
    assign w_full     = (r_count == DEPTH_CNT);
    assign w_match    = trig_match(r_pend_addr, trig_addr, trig_mask);
    assign w_entry    = {r_pend_write, r_pend_addr, r_pend_write ? HWDATA : HRDATA};

    // Pending address phase. A phase accepted in the arm cycle is kept.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_pend       <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_addr  <= '0;
        end else if (arm || HREADY) begin
            r_pend <= w_addr_acc;
            if (w_addr_acc) begin
                r_pend_write <= HWRITE;
                r_pend_addr  <= HADDR;
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_state <= StIdle;
            r_post  <= '0;
        end else begin
            r_state <= w_state_d;
            r_post  <= w_post_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_post_d  = r_post;
        if (arm) begin
            w_state_d = StArmed;
            w_post_d  = '0;
        end else begin
            case (r_state)
                StArmed: begin
                    if (w_wr && w_match) begin
                        if (POST_TRIG == 0) begin
                            w_state_d = StDone;
                        end else begin
                            w_state_d = StTriggered;
                            w_post_d  = POST_CNT_INIT;
                        end
                    end
                end
                StTriggered: begin
                    if (w_wr) begin
                        w_post_d = r_post - 1'b1;
                        if (r_post == DEPTH_LOG2'(1)) begin
                            w_state_d = StDone;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointers, occupancy and wrap flag.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (arm) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end else if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
                if (w_full) begin
                    // Overwrite the oldest entry: the read pointer follows.
                    r_rptr    <= r_rptr + 1'b1;
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    mfp_ahb_trace_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .i_clk   (SI_ClkIn),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (w_entry),
        .i_re    (w_pop),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    // RAM output is not reset; gate it so rd_data reads zero when idle.
    assign rd_data  = r_rd_valid ? w_ram_q : '0;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign count    = r_count;
    assign wrapped  = r_wrapped;

endmodule
